// File: rtl/vga_scan_gen_if.sv
// VGA scan bundle: pixel strobe, syncs, visible flag and coordinates.
// The generator drives it as master; display logic listens as slave.
interface vga_scan_gen_if #(
  parameter int w_x = 10,
  parameter int w_y = 9
);
  logic           pixel_clk_en;
  logic           hsync;
  logic           vsync;
  logic           display_on;
  logic [w_x-1:0] x;
  logic [w_y-1:0] y;
  logic           frame_start;

  modport master (
    output pixel_clk_en,
    output hsync,
    output vsync,
    output display_on,
    output x,
    output y,
    output frame_start
  );

  modport slave (
    input pixel_clk_en,
    input hsync,
    input vsync,
    input display_on,
    input x,
    input y,
    input frame_start
  );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: clock divider, h/v counters and
// registered sync/visible/coordinate decode.
module vga_scan_gen #(
  parameter int clk_mhz       = 50,
  parameter int pixel_mhz     = 25,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int h_front       = 16,
  parameter int h_sync        = 96,
  parameter int h_back        = 48,
  parameter int v_front       = 10,
  parameter int v_sync        = 2,
  parameter int v_back        = 33,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  vga_scan_gen_if.master vga
);

  localparam int N       = clk_mhz / pixel_mhz;
  localparam int H_TOTAL = screen_width + h_front + h_sync + h_back;
  localparam int V_TOTAL = screen_height + v_front + v_sync + v_back;
  localparam int W_H     = $clog2(H_TOTAL);
  localparam int W_V     = $clog2(V_TOTAL);
  localparam int W_D     = (N > 1) ? $clog2(N) : 1;
  localparam int HS_BEG  = screen_width + h_front;
  localparam int HS_END  = HS_BEG + h_sync;
  localparam int VS_BEG  = screen_height + v_front;
  localparam int VS_END  = VS_BEG + v_sync;

  localparam logic [W_D-1:0] D_LAST = W_D'(N - 1);
  localparam logic [W_H-1:0] H_LAST = W_H'(H_TOTAL - 1);
  localparam logic [W_V-1:0] V_LAST = W_V'(V_TOTAL - 1);

  generate
    if ((clk_mhz % pixel_mhz) != 0 || N < 1) begin : g_bad_ratio
      $error("vga_scan_gen: clk_mhz must be a multiple of pixel_mhz");
    end
  endgenerate

  logic           run;
  logic [W_D-1:0] div;
  logic [W_D-1:0] div_nxt;
  logic [W_H-1:0] h_cnt;
  logic [W_H-1:0] h_nxt;
  logic [W_V-1:0] v_cnt;
  logic [W_V-1:0] v_nxt;
  logic           en;

  logic           hs_d;
  logic           vs_d;
  logic           de_d;
  logic [w_x-1:0] x_d;
  logic [w_y-1:0] y_d;

  logic           hs_q;
  logic           vs_q;
  logic           de_q;
  logic [w_x-1:0] x_q;
  logic [w_y-1:0] y_q;

  // run holds the divider at 0 for the first cycle after reset,
  // so the first strobe lands in the Nth cycle after release.
  assign en = run && (div == D_LAST);

  always_comb begin
    div_nxt = '0;
    if (run && !en)
      div_nxt = div + 1'b1;
  end

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (en) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
  end

  // Decode from next-state counts so outputs move with the counters.
  always_comb begin
    de_d = (int'(h_nxt) < screen_width) &&
           (int'(v_nxt) < screen_height);
    hs_d = !((int'(h_nxt) >= HS_BEG) &&
             (int'(h_nxt) < HS_END));
    vs_d = !((int'(v_nxt) >= VS_BEG) &&
             (int'(v_nxt) < VS_END));
    x_d  = de_d ? h_nxt[w_x-1:0] : '0;
    y_d  = de_d ? v_nxt[w_y-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= 1'b0;
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b1;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      run   <= 1'b1;
      div   <= div_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign vga.pixel_clk_en = en;
  assign vga.frame_start  = en && (h_cnt == '0) && (v_cnt == '0);
  assign vga.hsync        = hs_q;
  assign vga.vsync        = vs_q;
  assign vga.display_on   = de_q;
  assign vga.x            = x_q;
  assign vga.y            = y_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a reduced 16x8 raster,
// with a divide-by-2 instance and a divide-by-1 instance.
module tb_vga_scan_gen;

  localparam int SW = 16;
  localparam int SH = 8;
  localparam int HT = 24;
  localparam int VT = 13;

  typedef struct packed {
    logic       en;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] x;
    logic [2:0] y;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_scan_gen_if #(.w_x(4), .w_y(3)) va ();
  vga_scan_gen_if #(.w_x(4), .w_y(3)) vb ();

  vga_scan_gen #(
    .clk_mhz(50), .pixel_mhz(25),
    .screen_width(SW), .screen_height(SH),
    .h_front(2), .h_sync(3), .h_back(3),
    .v_front(1), .v_sync(2), .v_back(2)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .vga(va)
  );

  vga_scan_gen #(
    .clk_mhz(25), .pixel_mhz(25),
    .screen_width(SW), .screen_height(SH),
    .h_front(2), .h_sync(3), .h_back(3),
    .v_front(1), .v_sync(2), .v_back(2)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .vga(vb)
  );

  always #5 clk = ~clk;

  pair_t q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    k      = 0;

  // Closed-form expectation for cycle k after release (k=0: reset).
  function automatic exp_t model(input int kk, input int n);
    exp_t e;
    int   p;
    int   h;
    int   v;
    e = '{en: 1'b0, fs: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b1,
          x: 4'd0, y: 3'd0};
    if (kk == 0) return e;
    p    = (kk - 1) / n;
    h    = p % HT;
    v    = (p / HT) % VT;
    e.en = (kk % n) == 0;
    e.de = (h < SW) && (v < SH);
    e.x  = e.de ? h[3:0] : 4'd0;
    e.y  = e.de ? v[2:0] : 3'd0;
    e.hs = !((h >= 18) && (h < 21));
    e.vs = !((v >= 9) && (v < 11));
    e.fs = e.en && (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic step(input logic r);
    pair_t pr;
    @(negedge clk);
    rst = r;
    @(posedge clk);
    if (r) k = 0;
    else   k++;
    pr.a = model(k, 2);
    pr.b = model(k, 1);
    q.push_back(pr);
  endtask

  int cyc      = 0;
  int fs_a_n   = 0;
  int fs_a_t   = 0;
  int per_a    = 0;
  int fs_b_n   = 0;
  int fs_b_t   = 0;
  int per_b    = 0;
  int de_cnt   = 0;
  int hs_cnt   = 0;
  int vs_cnt   = 0;
  int x_max    = 0;
  int y_max    = 0;

  initial begin : monitor
    pair_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("a_en", 32'(va.pixel_clk_en), 32'(e.a.en));
        chk("a_fs", 32'(va.frame_start), 32'(e.a.fs));
        chk("a_hsync", 32'(va.hsync), 32'(e.a.hs));
        chk("a_vsync", 32'(va.vsync), 32'(e.a.vs));
        chk("a_de", 32'(va.display_on), 32'(e.a.de));
        chk("a_x", 32'(va.x), 32'(e.a.x));
        chk("a_y", 32'(va.y), 32'(e.a.y));
        chk("b_en", 32'(vb.pixel_clk_en), 32'(e.b.en));
        chk("b_fs", 32'(vb.frame_start), 32'(e.b.fs));
        chk("b_hsync", 32'(vb.hsync), 32'(e.b.hs));
        chk("b_vsync", 32'(vb.vsync), 32'(e.b.vs));
        chk("b_de", 32'(vb.display_on), 32'(e.b.de));
        chk("b_x", 32'(vb.x), 32'(e.b.x));
        chk("b_y", 32'(vb.y), 32'(e.b.y));
        if (va.frame_start === 1'b1) begin
          if (fs_a_n == 1) per_a = cyc - fs_a_t;
          fs_a_t = cyc;
          fs_a_n++;
        end
        if (vb.frame_start === 1'b1) begin
          if (fs_b_n == 1) per_b = cyc - fs_b_t;
          fs_b_t = cyc;
          fs_b_n++;
        end
        if (fs_a_n == 1 && va.pixel_clk_en === 1'b1) begin
          if (va.display_on === 1'b1) de_cnt++;
          if (va.hsync === 1'b0) hs_cnt++;
          if (va.vsync === 1'b0) vs_cnt++;
          if (int'(va.x) > x_max) x_max = int'(va.x);
          if (int'(va.y) > y_max) y_max = int'(va.y);
        end
        cyc++;
      end
    end
  end

  initial begin : driver
    repeat (3) step(1'b1);
    repeat (700) step(1'b0);
    step(1'b1);
    // 183 cycles lands on h=19, v=3, inside the hsync pulse.
    repeat (183) step(1'b0);
    step(1'b1);
    repeat (20) step(1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("a_frame_period", 32'(per_a), 32'd624);
    chk("b_frame_period", 32'(per_b), 32'd312);
    chk("a_visible_strobes", 32'(de_cnt), 32'd128);
    chk("a_hsync_low_strobes", 32'(hs_cnt), 32'd39);
    chk("a_vsync_low_strobes", 32'(vs_cnt), 32'd48);
    chk("a_x_max", 32'(x_max), 32'd15);
    chk("a_y_max", 32'(y_max), 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 The block SHALL have parameter clk_mhz, default 50: system clock frequency in MHz.
REQ-002 The block SHALL have parameter pixel_mhz, default 25: pixel rate in MHz.
REQ-003 The block SHALL have parameters screen_width 640 and screen_height 480: visible pixels per line and visible lines per frame.
REQ-004 The block SHALL have parameters h_front 16, h_sync 96, h_back 48, v_front 10, v_sync 2, v_back 33: porch and sync lengths in pixels and lines.
REQ-005 The block SHALL have derived parameters w_x = $clog2(screen_width) and w_y = $clog2(screen_height).
REQ-006 clk  input  1: single system clock; all logic is on the rising edge.
REQ-007 rst  input  1: reset, synchronous and active-high.
REQ-008 pixel_clk_en  output  1: one-clk pixel strobe.
REQ-009 hsync  output  1: horizontal sync, active low.
REQ-010 vsync  output  1: vertical sync, active low.
REQ-011 display_on  output  1: current pixel is inside the visible area.
REQ-012 x  output  w_x: visible column.
REQ-013 y  output  w_y: visible row.
REQ-014 frame_start  output  1: one-clk pulse on the first pixel of each frame.

Function
REQ-015 Elaboration SHALL fail if clk_mhz % pixel_mhz != 0; define N = clk_mhz / pixel_mhz, which must be >= 1.
REQ-016 H_TOTAL SHALL equal screen_width + h_front + h_sync + h_back (800 at defaults), and V_TOTAL SHALL equal screen_height + v_front + v_sync + v_back (525 at defaults).
REQ-017 A divider counter SHALL count 0..N-1; pixel_clk_en SHALL be high exactly in the clk cycles where the divider equals N-1, with period N clk.
REQ-018 The first pixel_clk_en after reset release SHALL occur in the Nth clk cycle; for N = 1 it SHALL be high in every cycle after reset.
REQ-019 h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) SHALL advance only at the edge that ends a pixel_clk_en cycle.
REQ-020 h_cnt SHALL wrap from H_TOTAL-1 to 0, and v_cnt SHALL increment only on that wrap.
REQ-021 v_cnt SHALL wrap from V_TOTAL-1 to 0 when h_cnt also wraps.
REQ-022 The counter widths SHALL be sized to hold H_TOTAL-1 and V_TOTAL-1; the v counter is wider than w_y at defaults.
REQ-023 hsync, vsync, display_on, x and y SHALL be registered outputs decoded from the next-state counters, so they change at the same edge as h_cnt and v_cnt with no added lag.
REQ-024 display_on SHALL be 1 when h_cnt < screen_width and v_cnt < screen_height.
REQ-025 x SHALL equal h_cnt[w_x-1:0] and y SHALL equal v_cnt[w_y-1:0] while display_on is 1; both SHALL be 0 otherwise.
REQ-026 hsync SHALL be 0 when screen_width+h_front <= h_cnt < screen_width+h_front+h_sync (656..751 at defaults), and 1 otherwise.
REQ-027 vsync SHALL be 0 when screen_height+v_front <= v_cnt < screen_height+v_front+v_sync (490..491 at defaults), for the full line including the horizontal blanking, and 1 otherwise.
REQ-028 frame_start SHALL equal pixel_clk_en AND h_cnt==0 AND v_cnt==0, with h_cnt and v_cnt taken as the current registered values.
REQ-029 frame_start SHALL be high for exactly one clk per frame.
REQ-030 Outputs SHALL hold steady between pixel_clk_en strobes; no output other than pixel_clk_en and frame_start may change in a cycle that is not a pixel-advance edge.

Reset
REQ-031 While rst is high at an edge, the divider, h_cnt and v_cnt SHALL be 0.
REQ-032 While rst is high at an edge, the outputs SHALL be: pixel_clk_en=0, frame_start=0, hsync=1, vsync=1, display_on=1, x=0, y=0.
REQ-033 display_on SHALL be 1 during reset because counter 0,0 is visible.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately, with no partial sync pulse held.
REQ-035 After reset release, the first pixel_clk_en SHALL raise frame_start.

Verification
REQ-036 Defaults, release rst -> pixel_clk_en pattern 0,1,0,1...; frame_start on first strobe (clk 2); x = 0 for 2 clk, then 1.
REQ-037 Run one line -> x counts 0..639 with display_on=1; display_on=0 and x=0 for h 640..799; hsync low for exactly 96 strobes (192 clk) starting at h=656.
REQ-038 Run a full frame -> vsync low for exactly lines 490..491 (1600 strobes); y wraps 479 -> blanking -> 0; frame_start period = 800*525*2 = 840000 clk.
REQ-039 Assert rst for 1 clk at h=700, v=300 (hsync low) -> next cycle hsync=1, x=0, y=0, display_on=1; next frame_start occurs 2 clk after release.
REQ-040 Parameter clk_mhz=25, pixel_mhz=25 -> pixel_clk_en constantly 1 after reset; frame period 420000 clk; clk_mhz=50, pixel_mhz=30 -> elaboration error.
